pixel_sink: RTL and testbench



---
 rtl/pixel_sink.sv | 142 ++++++++++++++
 tb/tb_pixel_sink.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sink.sv
// pixel_sink: buffers the renderer pixel stream (po/xo/yo) in a small FIFO and
// drains it to a framebuffer write port with a req/ack handshake. Also reports
// the per-frame accepted-pixel count, a sticky overflow flag and a frame-done
// pulse.
// Optional feature macro: PIX_DEDUP_EN drops a pixel that repeats the last
// accepted {y, x} of the current frame.
module pixel_sink #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PTR_W      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busy,
   input  logic        po,
   input  logic [7:0]  xo,
   input  logic [7:0]  yo,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   output logic        frame_done,
   output logic [15:0] pix_cnt,
   output logic        ovf
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e         r_state;
   state_e         w_state_nxt;
   logic           r_busy_d;
   logic [PTR_W:0] r_wptr;
   logic [PTR_W:0] r_rptr;
   logic [15:0]    r_fifo [FIFO_DEPTH];
   logic [15:0]    r_pix_cnt;
   logic           r_ovf;

   logic           w_rise;
   logic           w_fall;
   logic           w_empty;
   logic           w_full;
   logic           w_pop;
   logic           w_accept;
   logic           w_dup;
   logic           w_cand;
   logic           w_push;
   logic           w_drop;
   logic [15:0]    w_pix;

   assign w_rise   = busy & ~r_busy_d;
   assign w_fall   = ~busy & r_busy_d;
   assign w_pix    = {yo, xo};
   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign w_pop    = ~w_empty & mem_ack;
   assign w_accept = (r_state == StRun) || (r_state == StDrain);
   assign w_cand   = po & w_accept & ~w_dup;
   // A same-cycle pop frees the slot, so a full FIFO can still take the pixel
   assign w_push   = w_cand & (~w_full | w_pop);
   assign w_drop   = w_cand & w_full & ~w_pop;

`ifdef PIX_DEDUP_EN
   logic [15:0] r_last_pix;
   logic        r_last_vld;

   assign w_dup = r_last_vld && (r_last_pix == w_pix);

   // Remember the last accepted pixel; forgotten at every frame start
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_vld <= 1'b0;
         r_last_pix <= 16'h0000;
      end else if (w_rise) begin
         r_last_vld <= 1'b0;
      end else if (w_push) begin
         r_last_vld <= 1'b1;
         r_last_pix <= w_pix;
      end
   end
`else
   assign w_dup = 1'b0;
`endif

   // Busy edge detector and FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy_d <= 1'b0;
         r_state  <= StIdle;
      end else begin
         r_busy_d <= busy;
         r_state  <= w_state_nxt;
      end
   end

   // Frame sequencing: only IDLE can start a frame; DRAIN waits for the FIFO
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_rise) w_state_nxt = StRun;
         StRun:   if (w_fall) w_state_nxt = StDrain;
         StDrain: if (w_empty && !w_push) w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // FIFO pointers; one extra bit distinguishes full from empty
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // FIFO storage; contents are only observed through a non-empty head
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= w_pix;
   end

   // Per-frame statistics, cleared when a frame starts from IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix_cnt <= 16'h0000;
         r_ovf     <= 1'b0;
      end else if ((r_state == StIdle) && w_rise) begin
         r_pix_cnt <= 16'h0000;
         r_ovf     <= 1'b0;
      end else begin
         if (w_push && (r_pix_cnt != 16'hFFFF)) r_pix_cnt <= r_pix_cnt + 16'd1;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   assign mem_req    = ~w_empty;
   assign mem_addr   = w_empty ? 16'h0000 : r_fifo[r_rptr[PTR_W-1:0]];
   assign frame_done = (r_state == StDone);
   assign pix_cnt    = r_pix_cnt;
   assign ovf        = r_ovf;

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: table-driven frames plus hand-written
// sequences for backpressure, overflow, full-with-pop and mid-frame reset.
module tb_pixel_sink;

`ifdef PIX_DEDUP_EN
   localparam bit DD = 1'b1;
`else
   localparam bit DD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, busy, po, mem_ack;
   logic [7:0]  xo, yo;
   logic        mem_req, frame_done, ovf;
   logic [15:0] mem_addr, pix_cnt;

   int n_tot = 0;
   int n_bad = 0;

   typedef struct {
      logic        rst, b, p;
      logic [7:0]  x, y;
      logic        a;
      logic        req;
      logic [15:0] addr;
      logic        done;
      logic [15:0] cnt;
      logic        ovf;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   pixel_sink #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .reset(reset), .busy(busy), .po(po), .xo(xo), .yo(yo),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .frame_done(frame_done), .pix_cnt(pix_cnt), .ovf(ovf)
   );

   function automatic vec_t v(int r, int b, int p, int x, int y, int a,
                              int q, int ad, int d, int c, int o);
      vec_t t;
      t.rst = 1'(r); t.b = 1'(b); t.p = 1'(p); t.x = 8'(x); t.y = 8'(y);
      t.a = 1'(a); t.req = 1'(q); t.addr = 16'(ad); t.done = 1'(d);
      t.cnt = 16'(c); t.ovf = 1'(o);
      return t;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic b, input logic p,
                      input logic [7:0] x, input logic [7:0] y, input logic a);
      reset = r; busy = b; po = p; xo = x; yo = y; mem_ack = a;
   endtask

   task automatic do_reset();
      drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         drv(tbl[i].rst, tbl[i].b, tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].a);
         chk($sformatf("%s[%0d].req", tag, i), 16'(mem_req), 16'(tbl[i].req));
         chk($sformatf("%s[%0d].addr", tag, i), mem_addr, tbl[i].addr);
         chk($sformatf("%s[%0d].done", tag, i), 16'(frame_done), 16'(tbl[i].done));
         chk($sformatf("%s[%0d].cnt", tag, i), pix_cnt, tbl[i].cnt);
         chk($sformatf("%s[%0d].ovf", tag, i), 16'(ovf), 16'(tbl[i].ovf));
         tick();
      end
      tbl.delete();
   endtask

   // Ack everything with busy low; writes must match exp_q in order, then one done
   task automatic drain_check(input string tag);
      int ndone = 0;
      for (int k = 0; k < 40 && ndone == 0; k++) begin
         drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
         if (frame_done) begin
            ndone++;
            chk({tag, ".pending_at_done"}, 16'(exp_q.size()), 16'd0);
         end
         if (mem_req) begin
            if (exp_q.size() == 0) begin
               n_tot++;
               n_bad++;
               $display("FAIL %s.extra_write: got %h want no write", tag, mem_addr);
            end else begin
               chk({tag, ".write_addr"}, mem_addr, exp_q.pop_front());
            end
         end
         tick();
      end
      chk({tag, ".done_seen"}, 16'(ndone), 16'd1);
      chk({tag, ".writes_left"}, 16'(exp_q.size()), 16'd0);
      chk({tag, ".done_single"}, 16'(frame_done), 16'd0);
      exp_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Basic frame: busy high 6 cycles, 3 pixels, ack held high
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,0,0));
      tbl.push_back(v(0,1,0,0,0,1, 0,0,0,0,0));
      tbl.push_back(v(0,1,1,3,5,1, 0,0,0,0,0));
      tbl.push_back(v(0,1,1,4,5,1, 1,'h0503,0,1,0));
      tbl.push_back(v(0,1,1,5,5,1, 1,'h0504,0,2,0));
      tbl.push_back(v(0,1,0,0,0,1, 1,'h0505,0,3,0));
      tbl.push_back(v(0,1,0,0,0,1, 0,0,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,1,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,3,0));
      run_tbl("basic");

      // Late po: pixel one cycle after busy falls lands in DRAIN
      tbl.push_back(v(0,1,0,0,0,0, 0,0,0,3,0));
      tbl.push_back(v(0,1,1,1,1,0, 0,0,0,0,0));
      tbl.push_back(v(0,0,1,2,1,0, 1,'h0101,0,1,0));
      tbl.push_back(v(0,0,1,3,1,0, 1,'h0101,0,2,0));
      tbl.push_back(v(0,0,0,0,0,1, 1,'h0101,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 1,'h0102,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 1,'h0103,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,1,3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,3,0));
      run_tbl("late");

      // Duplicate pixel (7,2),(7,2),(8,2)
      tbl.push_back(v(0,1,0,0,0,0, 0,0,0,3,0));
      tbl.push_back(v(0,1,1,7,2,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,1,7,2,0, 1,'h0207,0,1,0));
      tbl.push_back(v(0,1,1,8,2,1, 1,'h0207,0,DD?1:2,0));
      tbl.push_back(v(0,0,0,0,0,1, 1,DD?'h0208:'h0207,0,DD?2:3,0));
      tbl.push_back(v(0,0,0,0,0,1, DD?0:1,DD?0:'h0208,0,DD?2:3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,DD?1:0,DD?2:3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,DD?0:1,DD?2:3,0));
      tbl.push_back(v(0,0,0,0,0,1, 0,0,0,DD?2:3,0));
      run_tbl("dedup");

      // Backpressure: 10 stalled cycles, head must stay put
      do_reset();
      drv(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, 1'b1, 1'b1, 8'(3 + i), 8'h05, 1'b0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         drv(1'b0, (i < 2), 1'b0, 8'h00, 8'h00, 1'b0);
         chk($sformatf("bp.stall%0d.req", i), 16'(mem_req), 16'd1);
         chk($sformatf("bp.stall%0d.addr", i), mem_addr, 16'h0503);
         chk($sformatf("bp.stall%0d.done", i), 16'(frame_done), 16'd0);
         tick();
      end
      exp_q = '{16'h0503, 16'h0504, 16'h0505};
      drain_check("bp");
      chk("bp.cnt", pix_cnt, 16'd3);

      // Overflow: 10 po into an 8-deep FIFO with no acks
      do_reset();
      drv(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drv(1'b0, 1'b1, 1'b1, 8'(16 + i), 8'h01, 1'b0);
         tick();
         chk($sformatf("ovf.po%0d.cnt", i), pix_cnt, 16'((i < 8) ? i + 1 : 8));
         chk($sformatf("ovf.po%0d.ovf", i), 16'(ovf), 16'((i >= 8) ? 1 : 0));
         chk($sformatf("ovf.po%0d.addr", i), mem_addr, 16'h0110);
      end
      for (int i = 0; i < 8; i++) exp_q.push_back(16'h0110 + 16'(i));
      drain_check("ovf");
      drv(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk("ovf.next_frame.ovf", 16'(ovf), 16'd0);
      chk("ovf.next_frame.cnt", pix_cnt, 16'd0);

      // Full FIFO with simultaneous push and pop, then prove occupancy is 8
      for (int i = 0; i < 8; i++) begin
         drv(1'b0, 1'b1, 1'b1, 8'(32 + i), 8'h02, 1'b0);
         tick();
      end
      chk("fullpop.pre.cnt", pix_cnt, 16'd8);
      chk("fullpop.pre.ovf", 16'(ovf), 16'd0);
      drv(1'b0, 1'b1, 1'b1, 8'h30, 8'h02, 1'b1);
      tick();
      chk("fullpop.cnt", pix_cnt, 16'd9);
      chk("fullpop.ovf", 16'(ovf), 16'd0);
      chk("fullpop.addr", mem_addr, 16'h0221);
      drv(1'b0, 1'b1, 1'b1, 8'h31, 8'h02, 1'b0);
      tick();
      chk("fullpop.still_full.ovf", 16'(ovf), 16'd1);
      chk("fullpop.still_full.cnt", pix_cnt, 16'd9);
      for (int i = 1; i < 8; i++) exp_q.push_back(16'h0220 + 16'(i));
      exp_q.push_back(16'h0230);
      drain_check("fullpop");

      // Reset in DRAIN with 4 entries queued
      do_reset();
      drv(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 1'b1, 1'b1, 8'(64 + i), 8'h03, 1'b0);
         tick();
      end
      drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk("rst.pre.req", 16'(mem_req), 16'd1);
      chk("rst.pre.cnt", pix_cnt, 16'd4);
      drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      chk("rst.post.req", 16'(mem_req), 16'd0);
      chk("rst.post.addr", mem_addr, 16'h0000);
      chk("rst.post.cnt", pix_cnt, 16'd0);
      chk("rst.post.ovf", 16'(ovf), 16'd0);
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 1'b0, 1'b1, 8'h55, 8'h05, 1'b1);
         chk($sformatf("rst.idle%0d.req", i), 16'(mem_req), 16'd0);
         chk($sformatf("rst.idle%0d.done", i), 16'(frame_done), 16'd0);
         tick();
      end
      chk("rst.idle.cnt", pix_cnt, 16'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
